cu_fsm: RTL and testbench

- Multicycle control unit for the KGP-miniRISC core.
- Consumes `opcode_out`/`func_out` from `data_path` and drives every `data_path` control input: `reg_write`, `imm_mux_ctrl`, `alu_mux_ctrl`, `alu_op`, `dmem_enable`, `dmem_write_enable`, `reg_write_mux_ctrl`, `br_op`.
- Adds instruction-register load and PC-update strobes.
- Sits beside `data_path` in the top-level core and replaces hand-driven control.

---
 rtl/cu_fsm_pkg.sv | 57 +++++
 rtl/cu_fsm_decode.sv | 58 +++++
 rtl/cu_fsm.sv | 205 ++++++++++++++++++++
 tb/tb_cu_fsm.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cu_fsm_pkg.sv
// cu_fsm_pkg: shared definitions for the KGP-miniRISC multicycle control unit.
// Holds the state and instruction-class enums, opcode/func codes, ALU and branch
// encodings, register-write codes and the instruction legality check.
package cu_fsm_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU = 3'd0,
        CLS_LW  = 3'd1,
        CLS_SW  = 3'd2,
        CLS_BR  = 3'd3,
        CLS_BL  = 3'd4
    } cls_t;

    localparam logic [5:0] OP_RTYPE  = 6'd0;
    localparam logic [5:0] OP_ADDI   = 6'd1;
    localparam logic [5:0] OP_COMPI  = 6'd2;
    localparam logic [5:0] OP_LW     = 6'd3;
    localparam logic [5:0] OP_SW     = 6'd4;
    localparam logic [5:0] OP_BRANCH = 6'd5;

    // R-type func 0..9: add, comp, and, xor, shll, shrl, shllv, shrlv, shra, shrav
    localparam logic [5:0] FN_R_LAST  = 6'd9;
    // Branch func 0..6: br, bltz, bz, bnz, bl, bcy, bncy
    localparam logic [5:0] FN_BR_LAST = 6'd6;
    localparam logic [5:0] FN_BL      = 6'd4;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_COMP = 4'd1;

    localparam logic [1:0] RW_NONE = 2'b00;
    localparam logic [1:0] RW_RS   = 2'b01;
    localparam logic [1:0] RW_RT   = 2'b10;
    localparam logic [1:0] RW_RA   = 2'b11;

    localparam logic [1:0] RWM_PC4  = 2'b00;
    localparam logic [1:0] RWM_DMEM = 2'b01;
    localparam logic [1:0] RWM_ALU  = 2'b10;

    function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            OP_RTYPE:                          return (fn <= FN_R_LAST);
            OP_ADDI, OP_COMPI, OP_LW, OP_SW:   return 1'b1;
            OP_BRANCH:                         return (fn <= FN_BR_LAST);
            default:                           return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cu_fsm_decode.sv
// cu_decode: combinational instruction decoder for cu_fsm.
// Ports:
//   opcode, func        in   latched instruction fields
//   cls                 out  instruction class (ALU, lw, sw, branch, bl)
//   alu_op              out  ALU operation for the class
//   imm_mux_ctrl        out  1 = sign-extend immediate
//   alu_mux_ctrl        out  1 = ALU B operand from immediate
//   br_op               out  {valid, condition} for the branch group, else 0
module cu_decode
    import cu_fsm_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    output cls_t       cls,
    output logic [3:0] alu_op,
    output logic       imm_mux_ctrl,
    output logic       alu_mux_ctrl,
    output logic [4:0] br_op
);

    always_comb begin
        cls          = CLS_ALU;
        alu_op       = ALU_ADD;
        imm_mux_ctrl = 1'b0;
        alu_mux_ctrl = 1'b0;
        br_op        = 5'd0;
        case (opcode)
            OP_RTYPE: begin
                alu_op = func[3:0];
            end
            OP_ADDI: begin
                imm_mux_ctrl = 1'b1;
                alu_mux_ctrl = 1'b1;
            end
            OP_COMPI: begin
                alu_op       = ALU_COMP;
                imm_mux_ctrl = 1'b1;
                alu_mux_ctrl = 1'b1;
            end
            OP_LW: begin
                cls          = CLS_LW;
                imm_mux_ctrl = 1'b1;
                alu_mux_ctrl = 1'b1;
            end
            OP_SW: begin
                cls          = CLS_SW;
                imm_mux_ctrl = 1'b1;
                alu_mux_ctrl = 1'b1;
            end
            OP_BRANCH: begin
                cls   = (func == FN_BL) ? CLS_BL : CLS_BR;
                br_op = {1'b1, func[3:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/cu_fsm.sv
// cu_fsm: multicycle control unit for the KGP-miniRISC core. Sequences
// FETCH/DECODE/EXEC/MEM/WB and drives all data_path control inputs as Moore
// outputs of the state and the instruction fields latched in DECODE.
// Ports:
//   clk, rst                      core clock, synchronous active-high reset
//   opcode_in, func_in            instruction fields from data_path
//   ir_load, pc_en                IR load and PC update strobes
//   reg_write, reg_write_mux_ctrl register-file write target and source
//   imm_mux_ctrl, alu_mux_ctrl    immediate extension and ALU B select
//   alu_op                        ALU operation
//   dmem_enable, dmem_write_enable data memory strobes
//   br_op                         {branch valid, condition}
//   halted, illegal               parked in HALT, sticky illegal instruction
//   instr_count                   retired-instruction count (CU_PERF_CNT_EN only)
// Optional feature: define CU_PERF_CNT_EN to add the saturating instr_count port.
//
// state  | meaning
// FETCH  | load IR from imem
// DECODE | latch opcode/func, pick EXEC or HALT
// EXEC   | ALU inputs stable; branches update PC here
// MEM    | data memory access (lw/sw); sw retires here
// WB     | register write-back
// HALT   | parked until rst (halt opcode or illegal instruction)
module cu_fsm
    import cu_fsm_pkg::*;
#(
    parameter logic [5:0] HALT_OPCODE = 6'h3F
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode_in,
    input  logic [5:0] func_in,
    output logic       ir_load,
    output logic       pc_en,
    output logic [1:0] reg_write,
    output logic       imm_mux_ctrl,
    output logic       alu_mux_ctrl,
    output logic [3:0] alu_op,
    output logic       dmem_enable,
    output logic       dmem_write_enable,
    output logic [1:0] reg_write_mux_ctrl,
    output logic [4:0] br_op,
    output logic       halted,
`ifdef CU_PERF_CNT_EN
    output logic       illegal,
    output logic [31:0] instr_count
`else
    output logic       illegal
`endif
);

    state_t     state, state_nxt;
    logic [5:0] op_q, func_q;
    logic       illegal_q;

    cls_t       dec_cls;
    logic [3:0] dec_alu_op;
    logic       dec_imm, dec_amux;
    logic [4:0] dec_br_op;

    // alu_hold presents the decoded ALU controls; br_en presents br_op
    logic       ir_load_c, pc_en_c, alu_hold, br_en, den_c, dwe_c, halted_c;
    logic [1:0] rw_c, rwm_c;

    cu_decode u_decode (
        .opcode       (op_q),
        .func         (func_q),
        .cls          (dec_cls),
        .alu_op       (dec_alu_op),
        .imm_mux_ctrl (dec_imm),
        .alu_mux_ctrl (dec_amux),
        .br_op        (dec_br_op)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_FETCH;
            op_q      <= 6'd0;
            func_q    <= 6'd0;
            illegal_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_DECODE) begin
                op_q   <= opcode_in;
                func_q <= func_in;
                if (opcode_in != HALT_OPCODE && !is_legal(opcode_in, func_in))
                    illegal_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        ir_load_c = 1'b0;
        pc_en_c   = 1'b0;
        alu_hold  = 1'b0;
        br_en     = 1'b0;
        den_c     = 1'b0;
        dwe_c     = 1'b0;
        halted_c  = 1'b0;
        rw_c      = RW_NONE;
        rwm_c     = RWM_PC4;
        case (state)
            ST_FETCH: begin
                ir_load_c = 1'b1;
                state_nxt = ST_DECODE;
            end
            ST_DECODE: begin
                if (opcode_in == HALT_OPCODE || !is_legal(opcode_in, func_in))
                    state_nxt = ST_HALT;
                else
                    state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                case (dec_cls)
                    CLS_ALU: begin
                        alu_hold  = 1'b1;
                        state_nxt = ST_WB;
                    end
                    CLS_LW, CLS_SW: begin
                        alu_hold  = 1'b1;
                        state_nxt = ST_MEM;
                    end
                    CLS_BL: begin
                        br_en     = 1'b1;
                        pc_en_c   = 1'b1;
                        state_nxt = ST_WB;
                    end
                    default: begin
                        br_en     = 1'b1;
                        pc_en_c   = 1'b1;
                        state_nxt = ST_FETCH;
                    end
                endcase
            end
            ST_MEM: begin
                alu_hold = 1'b1;
                den_c    = 1'b1;
                if (dec_cls == CLS_SW) begin
                    dwe_c     = 1'b1;
                    pc_en_c   = 1'b1;
                    state_nxt = ST_FETCH;
                end else begin
                    state_nxt = ST_WB;
                end
            end
            ST_WB: begin
                state_nxt = ST_FETCH;
                case (dec_cls)
                    CLS_ALU: begin
                        alu_hold = 1'b1;
                        rw_c     = RW_RS;
                        rwm_c    = RWM_ALU;
                        pc_en_c  = 1'b1;
                    end
                    CLS_LW: begin
                        alu_hold = 1'b1;
                        den_c    = 1'b1;
                        rw_c     = RW_RT;
                        rwm_c    = RWM_DMEM;
                        pc_en_c  = 1'b1;
                    end
                    CLS_BL: begin
                        rw_c  = RW_RA;
                        rwm_c = RWM_PC4;
                    end
                    default: ;
                endcase
            end
            ST_HALT: begin
                halted_c = 1'b1;
            end
            default: state_nxt = ST_FETCH;
        endcase
    end

    // rst forces every output low in the cycle it is sampled, so strobes of an
    // interrupted instruction never reach the data path.
    assign ir_load            = ir_load_c & ~rst;
    assign pc_en              = pc_en_c & ~rst;
    assign reg_write          = rst ? RW_NONE : rw_c;
    assign reg_write_mux_ctrl = rst ? RWM_PC4 : rwm_c;
    assign alu_op             = (alu_hold && !rst) ? dec_alu_op : 4'd0;
    assign imm_mux_ctrl       = alu_hold & dec_imm & ~rst;
    assign alu_mux_ctrl       = alu_hold & dec_amux & ~rst;
    assign br_op              = (br_en && !rst) ? dec_br_op : 5'd0;
    assign dmem_enable        = den_c & ~rst;
    assign dmem_write_enable  = dwe_c & ~rst;
    assign halted             = halted_c & ~rst;
    assign illegal            = illegal_q & ~rst;

`ifdef CU_PERF_CNT_EN
    logic [31:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= 32'd0;
        else if (pc_en_c && cnt_q != 32'hFFFF_FFFF)
            cnt_q <= cnt_q + 32'd1;
    end

    assign instr_count = rst ? 32'd0 : cnt_q;
`endif

endmodule

// File: tb/tb_cu_fsm.sv
module tb_cu_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode_in, func_in;
    logic       ir_load, pc_en, imm_mux_ctrl, alu_mux_ctrl;
    logic       dmem_enable, dmem_write_enable, halted, illegal;
    logic [1:0] reg_write, reg_write_mux_ctrl;
    logic [3:0] alu_op;
    logic [4:0] br_op;
`ifdef CU_PERF_CNT_EN
    logic [31:0] instr_count;
`endif

    always #5 clk = ~clk;

    cu_fsm dut (
        .clk                (clk),
        .rst                (rst),
        .opcode_in          (opcode_in),
        .func_in            (func_in),
        .ir_load            (ir_load),
        .pc_en              (pc_en),
        .reg_write          (reg_write),
        .imm_mux_ctrl       (imm_mux_ctrl),
        .alu_mux_ctrl       (alu_mux_ctrl),
        .alu_op             (alu_op),
        .dmem_enable        (dmem_enable),
        .dmem_write_enable  (dmem_write_enable),
        .reg_write_mux_ctrl (reg_write_mux_ctrl),
        .br_op              (br_op),
        .halted             (halted),
`ifdef CU_PERF_CNT_EN
        .illegal            (illegal),
        .instr_count        (instr_count)
`else
        .illegal            (illegal)
`endif
    );

    typedef struct packed {
        logic        ir_load;
        logic        pc_en;
        logic [1:0]  rw;
        logic        imm;
        logic        amux;
        logic [3:0]  alu_op;
        logic        den;
        logic        dwe;
        logic [1:0]  rwm;
        logic [4:0]  br_op;
        logic        halted;
        logic        illegal;
        logic [31:0] cnt;
    } vec_t;

    vec_t  exp_q[$];
    string tag_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    cnt_model = 0;

    // Instruction class from the opcode map:
    // 0 R-type, 1 addi, 2 compi, 3 lw, 4 sw, 5 branch, 6 bl, 7 halt, 8 illegal
    function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h3F)               return 7;
        if (op == 6'd0 && fn <= 6'd9)  return 0;
        if (op == 6'd1)                return 1;
        if (op == 6'd2)                return 2;
        if (op == 6'd3)                return 3;
        if (op == 6'd4)                return 4;
        if (op == 6'd5 && fn == 6'd4)  return 6;
        if (op == 6'd5 && fn <= 6'd6)  return 5;
        return 8;
    endfunction

    task automatic push(input vec_t v, input string tag);
        vec_t e;
        e = v;
`ifdef CU_PERF_CNT_EN
        e.cnt = cnt_model;
`else
        e.cnt = 32'd0;
`endif
        exp_q.push_back(e);
        tag_q.push_back(tag);
        if (v.pc_en) cnt_model++;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        cnt_model = 0;
        repeat (n) begin
            push('0, "reset");
            @(posedge clk); #1;
        end
        rst = 1'b0;
    endtask

    // Called at the start of a FETCH cycle. Builds the per-cycle expected
    // outputs of one instruction, queues the first 'cut' of them (all if 0),
    // then steps the clock over those cycles.
    task automatic issue(input logic [5:0] op, input logic [5:0] fn, input string name,
                         input int cut, input int nhalt);
        vec_t tr[$];
        vec_t v, a;
        int   c, n;
        c = classify(op, fn);
        opcode_in = op;
        func_in   = fn;
        v = '0; v.ir_load = 1'b1; tr.push_back(v);
        tr.push_back('0);
        a = '0;
        case (c)
            0: a.alu_op = fn[3:0];
            1: begin a.imm = 1'b1; a.amux = 1'b1; end
            2: begin a.alu_op = 4'd1; a.imm = 1'b1; a.amux = 1'b1; end
            3, 4: begin a.imm = 1'b1; a.amux = 1'b1; end
            default: ;
        endcase
        case (c)
            0, 1, 2: begin
                tr.push_back(a);
                v = a; v.rw = 2'b01; v.rwm = 2'b10; v.pc_en = 1'b1; tr.push_back(v);
            end
            3: begin
                tr.push_back(a);
                v = a; v.den = 1'b1; tr.push_back(v);
                v = a; v.den = 1'b1; v.rw = 2'b10; v.rwm = 2'b01; v.pc_en = 1'b1; tr.push_back(v);
            end
            4: begin
                tr.push_back(a);
                v = a; v.den = 1'b1; v.dwe = 1'b1; v.pc_en = 1'b1; tr.push_back(v);
            end
            5, 6: begin
                v = '0; v.br_op = {1'b1, fn[3:0]}; v.pc_en = 1'b1; tr.push_back(v);
                if (c == 6) begin
                    v = '0; v.rw = 2'b11; v.rwm = 2'b00; tr.push_back(v);
                end
            end
            default: begin
                repeat (nhalt) begin
                    v = '0; v.halted = 1'b1; v.illegal = (c == 8); tr.push_back(v);
                end
            end
        endcase
        n = (cut > 0 && cut < tr.size()) ? cut : tr.size();
        for (int i = 0; i < n; i++) push(tr[i], $sformatf("%s.c%0d", name, i));
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Monitor: pops one expectation per cycle and compares on the falling edge.
    initial begin
        vec_t  e, a;
        string t;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                a = '0;
                a.ir_load = ir_load;      a.pc_en  = pc_en;
                a.rw      = reg_write;    a.imm    = imm_mux_ctrl;
                a.amux    = alu_mux_ctrl; a.alu_op = alu_op;
                a.den     = dmem_enable;  a.dwe    = dmem_write_enable;
                a.rwm     = reg_write_mux_ctrl;
                a.br_op   = br_op;        a.halted = halted;
                a.illegal = illegal;
`ifdef CU_PERF_CNT_EN
                a.cnt     = instr_count;
`endif
                n_cmp++;
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL %s: got %h expected %h", t, a, e);
                end
            end
        end
    end

    initial begin
        int         r, k;
        logic [5:0] op, fn;
        rst = 1'b1;
        opcode_in = 6'd0;
        func_in = 6'd0;
        @(posedge clk); #1;
        do_reset(3);

        issue(6'd0, 6'd3, "xor", 0, 0);
        issue(6'd3, 6'd5, "lw", 0, 0);
        issue(6'd4, 6'd0, "sw", 0, 0);
        issue(6'd5, 6'd2, "bz", 0, 0);
        issue(6'd5, 6'd4, "bl", 0, 0);
        issue(6'd1, 6'd9, "addi", 0, 0);
        issue(6'd2, 6'd0, "compi", 0, 0);

        do_reset(1);
        issue(6'd0, 6'd3, "xor1", 0, 0);
        issue(6'd0, 6'd3, "xor2", 0, 0);
        issue(6'd0, 6'd3, "xor3", 0, 0);
        issue(6'd4, 6'd1, "sw4", 0, 0);
        issue(6'd0, 6'd9, "shrav_after4", 0, 0);

        issue(6'h3F, 6'd0, "halt", 0, 20);
        do_reset(1);
        issue(6'h2A, 6'd0, "illegal", 0, 20);
        do_reset(1);
        issue(6'd0, 6'd10, "bad_func", 0, 4);
        do_reset(1);
        issue(6'd3, 6'd0, "lw_cut", 3, 0);
        do_reset(1);

        for (int i = 0; i < 150; i++) begin
            r  = $urandom_range(0, 99);
            fn = 6'($urandom_range(0, 63));
            if (r < 40)      begin op = 6'd0; fn = 6'($urandom_range(0, 9)); end
            else if (r < 50) op = 6'd1;
            else if (r < 58) op = 6'd2;
            else if (r < 68) op = 6'd3;
            else if (r < 78) op = 6'd4;
            else if (r < 92) begin op = 6'd5; fn = 6'($urandom_range(0, 6)); end
            else if (r < 96) op = 6'h3F;
            else begin
                k = $urandom_range(0, 2);
                if (k == 0)      op = 6'($urandom_range(6, 62));
                else if (k == 1) begin op = 6'd0; fn = 6'($urandom_range(10, 63)); end
                else             begin op = 6'd5; fn = 6'($urandom_range(7, 63)); end
            end
            issue(op, fn, $sformatf("rnd%0d", i), 0, 3);
            if (classify(op, fn) >= 7) do_reset(1);
        end
        issue(6'd0, 6'd0, "add_last", 0, 0);

        for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        if (n_cmp < 12) begin
            n_bad++;
            $display("FAIL count: got %0d compared expected at least 12", n_cmp);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
